// File: rtl/dg_pkg.sv
// -----------------------------------------------------------------------------
// dg_pkg
// Shared definitions for the data-generation packet path.
//   - Header word field positions and widths (da, prior, len, seq)
//   - Payload word field positions and widths (port, seq slice, word index)
//   - Packet generator FSM state encoding
//   - Helpers that pack header and payload words from their fields
// No ports: this is a package.
// -----------------------------------------------------------------------------
package dg_pkg;

    localparam int WORD_W    = 32;

    // Header word layout
    localparam int DA_LSB    = 0;
    localparam int DA_W      = 4;
    localparam int PRIOR_LSB = 4;
    localparam int PRIOR_W   = 3;
    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 10;
    localparam int SEQ_LSB   = 17;
    localparam int SEQ_W     = 15;

    // Payload word layout; bits [15:10] are always zero
    localparam int PAY_IDX_LSB  = 0;
    localparam int PAY_IDX_W    = 10;
    localparam int PAY_SEQ_LSB  = 16;
    localparam int PAY_SEQ_W    = 12;
    localparam int PAY_PORT_LSB = 28;
    localparam int PAY_PORT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] make_hdr(
        input logic [DA_W-1:0]    da,
        input logic [PRIOR_W-1:0] prior,
        input logic [LEN_W-1:0]   len,
        input logic [SEQ_W-1:0]   seq
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[DA_LSB    +: DA_W]    = da;
        w[PRIOR_LSB +: PRIOR_W] = prior;
        w[LEN_LSB   +: LEN_W]   = len;
        w[SEQ_LSB   +: SEQ_W]   = seq;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] make_pay(
        input logic [PAY_PORT_W-1:0] port,
        input logic [PAY_SEQ_W-1:0]  seq_lo,
        input logic [PAY_IDX_W-1:0]  idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[PAY_PORT_LSB +: PAY_PORT_W] = port;
        w[PAY_SEQ_LSB  +: PAY_SEQ_W]  = seq_lo;
        w[PAY_IDX_LSB  +: PAY_IDX_W]  = idx;
        return w;
    endfunction

endpackage

// File: rtl/dg_pkt_gen_if.sv
// -----------------------------------------------------------------------------
// dg_pkt_gen_if
// Stream port from the packet generator into one cache write port.
// Handshake: a word transfers on a clock edge where o_vld && i_rdy are both 1.
// Once o_vld rises with a word, o_data/o_sop/o_eop/o_prior stay stable and
// o_vld stays high until that word transfers; i_rdy is ignored while o_vld=0.
//   o_data  [31:0] stream word
//   o_vld          word valid
//   o_sop          first word of packet (header)
//   o_eop          last word of packet
//   o_prior [2:0]  packet priority sideband
//   i_rdy          downstream accepts the word
// Modports: master = generator side, slave = cache side.
// -----------------------------------------------------------------------------
interface dg_pkt_gen_if;
    import dg_pkg::*;

    logic [WORD_W-1:0]  o_data;
    logic               o_vld;
    logic               o_sop;
    logic               o_eop;
    logic [PRIOR_W-1:0] o_prior;
    logic               i_rdy;

    modport master (
        output o_data, o_vld, o_sop, o_eop, o_prior,
        input  i_rdy
    );

    modport slave (
        input  o_data, o_vld, o_sop, o_eop, o_prior,
        output i_rdy
    );

endinterface

// File: rtl/dg_pkt_gen.sv
// -----------------------------------------------------------------------------
// dg_pkt_gen
// Packet generator: accepts one command (da, prior, len) while idle and
// streams a header word followed by len payload words under backpressure.
// Payload words are derived from PORT_ID, the packet seq and the word index,
// so a checker can rebuild every word from the header alone.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_da/i_prior/i_len/i_vld   command; taken on i_vld while o_ready=1
//   o_ready          idle, a command is accepted this cycle (combinational)
//   st               stream master (data/vld/sop/eop/prior out, rdy in)
//   o_busy           packet in progress (combinational, = !o_ready)
//   o_pkt_cnt        packets completed, wraps
//   o_cmd_drop       one-cycle pulse after i_vld arrived while busy
//   dbg_state        current FSM state
// -----------------------------------------------------------------------------
module dg_pkt_gen
    import dg_pkg::*;
#(
    parameter logic [PAY_PORT_W-1:0] PORT_ID = 4'd0,
    parameter int                    CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DA_W-1:0]    i_da,
    input  logic [PRIOR_W-1:0] i_prior,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_vld,
    output logic               o_ready,
    dg_pkt_gen_if.master       st,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_pkt_cnt,
    output logic               o_cmd_drop,
    output state_t             dbg_state
);

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [PAY_IDX_W-1:0] idx_q, idx_d;
    logic [PAY_IDX_W-1:0] idx_nxt;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [PAY_SEQ_W-1:0] pseq_q, pseq_d;   // seq slice of the packet in flight
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WORD_W-1:0]    data_q, data_d;
    logic                 vld_q, vld_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic [PRIOR_W-1:0]   prior_q, prior_d;
    logic                 drop_q, drop_d;

    logic                 accept;

    assign accept  = vld_q && st.i_rdy;
    assign idx_nxt = idx_q + PAY_IDX_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and next registered outputs
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        pseq_d  = pseq_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        prior_d = prior_q;
        drop_d  = i_vld && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                data_d  = '0;
                vld_d   = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
                prior_d = '0;
                if (i_vld) begin
                    state_d = ST_HDR;
                    len_d   = i_len;
                    pseq_d  = seq_q[PAY_SEQ_W-1:0];
                    data_d  = make_hdr(i_da, i_prior, i_len, seq_q);
                    vld_d   = 1'b1;
                    sop_d   = 1'b1;
                    eop_d   = (i_len == '0);
                    prior_d = i_prior;
                end
            end

            ST_HDR, ST_PAY: begin
                if (accept) begin
                    if (eop_q) begin
                        // Last word of the packet has transferred
                        state_d = ST_IDLE;
                        seq_d   = seq_q + SEQ_W'(1);
                        cnt_d   = cnt_q + CNT_W'(1);
                        data_d  = '0;
                        vld_d   = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        prior_d = '0;
                    end else if (state_q == ST_HDR) begin
                        state_d = ST_PAY;
                        idx_d   = '0;
                        data_d  = make_pay(PORT_ID, pseq_q, '0);
                        sop_d   = 1'b0;
                        eop_d   = (len_q == LEN_W'(1));
                    end else begin
                        // len_q >= 1 in PAY, so len_q - 1 cannot underflow
                        idx_d   = idx_nxt;
                        data_d  = make_pay(PORT_ID, pseq_q, idx_nxt);
                        eop_d   = (idx_nxt == len_q - LEN_W'(1));
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            pseq_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            prior_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            len_q   <= len_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            pseq_q  <= pseq_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            prior_q <= prior_d;
            drop_q  <= drop_d;
        end
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_busy     = !o_ready;
    assign o_pkt_cnt  = cnt_q;
    assign o_cmd_drop = drop_q;
    assign dbg_state  = state_q;

    assign st.o_data  = data_q;
    assign st.o_vld   = vld_q;
    assign st.o_sop   = sop_q;
    assign st.o_eop   = eop_q;
    assign st.o_prior = prior_q;

endmodule

// File: tb/tb_dg_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_dg_pkt_gen
// Directed bench for dg_pkt_gen with PORT_ID=5, CNT_W=16. Expected stream
// words ({prior, sop, eop, data}) are hand-computed and queued in exp_q; a
// negedge monitor compares every accepted word and every stalled word
// against the queue.
// -----------------------------------------------------------------------------
module tb_dg_pkt_gen;
    import dg_pkg::*;

    localparam int W = 37;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         i_da = '0;
    logic [2:0]         i_prior = '0;
    logic [9:0]         i_len = '0;
    logic               i_vld = 1'b0;
    logic               o_ready;
    logic               o_busy;
    logic [15:0]        o_pkt_cnt;
    logic               o_cmd_drop;
    state_t             dbg_state;

    dg_pkt_gen_if st_if ();

    int                 n_vec = 0;
    int                 n_err = 0;
    int                 acc_cnt = 0;
    bit                 sb_en = 1'b1;
    logic [W-1:0]       exp_q[$];
    logic [W-1:0]       obs;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dg_pkt_gen #(.PORT_ID(4'd5), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_da       (i_da),
        .i_prior    (i_prior),
        .i_len      (i_len),
        .i_vld      (i_vld),
        .o_ready    (o_ready),
        .st         (st_if.master),
        .o_busy     (o_busy),
        .o_pkt_cnt  (o_pkt_cnt),
        .o_cmd_drop (o_cmd_drop),
        .dbg_state  (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && st_if.o_vld && st_if.i_rdy) acc_cnt++;
        if (rst_n && sb_en && st_if.o_vld) begin
            obs = {st_if.o_prior, st_if.o_sop, st_if.o_eop, st_if.o_data};
            if (exp_q.size() == 0)
                check("sb_extra", st_if.o_vld, 1'b0);
            else if (st_if.i_rdy)
                check("sb_word", obs, exp_q.pop_front());
            else
                check("sb_stall", obs, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_push(input logic [2:0] prior, input logic sop, input logic eop,
                            input logic [31:0] data);
        exp_q.push_back({prior, sop, eop, data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] da, input logic [2:0] prior, input logic [9:0] len);
        int n = 0;
        while (!o_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!o_ready) check("ready_timeout", o_ready, 1'b1);
        i_da    = da;
        i_prior = prior;
        i_len   = len;
        i_vld   = 1'b1;
        tick();
        i_vld   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!o_ready && n < 2000) begin
            tick();
            n++;
        end
        check(tag, o_ready, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc0;
        logic [2:0] pat [3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        st_if.i_rdy = 1'b1;

        // Reset values while held in reset
        tick();
        tick();
        check("rst_data",  st_if.o_data, 32'h0);
        check("rst_vld",   st_if.o_vld, 1'b0);
        check("rst_sop",   st_if.o_sop, 1'b0);
        check("rst_eop",   st_if.o_eop, 1'b0);
        check("rst_prior", st_if.o_prior, 3'd0);
        check("rst_drop",  o_cmd_drop, 1'b0);
        check("rst_cnt",   o_pkt_cnt, 16'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", o_ready, 1'b1);
        check("rst_busy",  o_busy, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        // Basic packet: da=3 prior=2 len=3, seq 0
        exp_push(3'd2, 1'b1, 1'b0, 32'h0000_01A3);
        exp_push(3'd2, 1'b0, 1'b0, 32'h5000_0000);
        exp_push(3'd2, 1'b0, 1'b0, 32'h5000_0001);
        exp_push(3'd2, 1'b0, 1'b1, 32'h5000_0002);
        send_cmd(4'd3, 3'd2, 10'd3);
        check("basic_hdr_vld", st_if.o_vld, 1'b1);
        check("basic_busy", o_busy, 1'b1);
        wait_idle("basic_idle");
        check("basic_cnt", o_pkt_cnt, 16'd1);
        check("basic_q", exp_q.size(), 0);

        // len=0: da=A prior=7, seq 1
        exp_push(3'd7, 1'b1, 1'b1, 32'h0002_007A);
        send_cmd(4'hA, 3'd7, 10'd0);
        check("len0_word", {st_if.o_vld, st_if.o_sop, st_if.o_eop, st_if.o_data},
              {3'b111, 32'h0002_007A});
        check("len0_ready_lo", o_ready, 1'b0);
        tick();
        check("len0_ready_hi", o_ready, 1'b1);
        check("len0_cnt", o_pkt_cnt, 16'd2);
        check("len0_vld_off", st_if.o_vld, 1'b0);

        // Backpressure: len=4, i_rdy pattern 1,0,0 repeating, seq 2
        exp_push(3'd1, 1'b1, 1'b0, 32'h0004_0211);
        exp_push(3'd1, 1'b0, 1'b0, 32'h5002_0000);
        exp_push(3'd1, 1'b0, 1'b0, 32'h5002_0001);
        exp_push(3'd1, 1'b0, 1'b0, 32'h5002_0002);
        exp_push(3'd1, 1'b0, 1'b1, 32'h5002_0003);
        acc0 = acc_cnt;
        send_cmd(4'd1, 3'd1, 10'd4);
        for (int c = 0; c < 200 && !o_ready; c++) begin
            st_if.i_rdy = pat[c % 3][0];
            tick();
        end
        st_if.i_rdy = 1'b1;
        check("bp_idle", o_ready, 1'b1);
        check("bp_words", acc_cnt - acc0, 5);
        check("bp_cnt", o_pkt_cnt, 16'd3);
        check("bp_q", exp_q.size(), 0);

        // Command during PAY is dropped: len=2 da=F prior=0, seq 3
        exp_push(3'd0, 1'b1, 1'b0, 32'h0006_010F);
        exp_push(3'd0, 1'b0, 1'b0, 32'h5003_0000);
        exp_push(3'd0, 1'b0, 1'b1, 32'h5003_0001);
        acc0 = acc_cnt;
        send_cmd(4'hF, 3'd0, 10'd2);
        tick();
        check("drop_in_pay", dbg_state, ST_PAY);
        i_da = 4'd9; i_prior = 3'd6; i_len = 10'd7;
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        check("drop_pulse", o_cmd_drop, 1'b1);
        tick();
        check("drop_pulse_end", o_cmd_drop, 1'b0);
        check("drop_idle", o_ready, 1'b1);
        tick();
        tick();
        tick();
        check("drop_no_extra", st_if.o_vld, 1'b0);
        check("drop_words", acc_cnt - acc0, 3);
        check("drop_cnt", o_pkt_cnt, 16'd4);

        // Reset in the middle of len=10: da=1 prior=5, seq 4
        exp_push(3'd5, 1'b1, 1'b0, 32'h0008_0551);
        exp_push(3'd5, 1'b0, 1'b0, 32'h5004_0000);
        exp_push(3'd5, 1'b0, 1'b0, 32'h5004_0001);
        send_cmd(4'd1, 3'd5, 10'd10);
        tick();
        tick();
        tick();
        check("abort_vld_before", st_if.o_vld, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_data",  st_if.o_data, 32'h0);
        check("abort_vld",   st_if.o_vld, 1'b0);
        check("abort_sop",   st_if.o_sop, 1'b0);
        check("abort_eop",   st_if.o_eop, 1'b0);
        check("abort_prior", st_if.o_prior, 3'd0);
        check("abort_cnt",   o_pkt_cnt, 16'd0);
        check("abort_q", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_ready", o_ready, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        // Next packet starts again at seq 0: da=2 prior=3 len=1
        exp_push(3'd3, 1'b1, 1'b0, 32'h0000_00B2);
        exp_push(3'd3, 1'b0, 1'b1, 32'h5000_0000);
        send_cmd(4'd2, 3'd3, 10'd1);
        check("abort_seq0_hdr", st_if.o_data, 32'h0000_00B2);
        wait_idle("abort_next_idle");
        check("abort_next_cnt", o_pkt_cnt, 16'd1);

        // seq wrap: 32768 len=0 packets after reset, then one more
        do_reset();
        sb_en = 1'b0;
        for (int k = 0; k < 32768; k++) begin
            i_da = '0; i_prior = '0; i_len = '0;
            i_vld = 1'b1;
            tick();
            i_vld = 1'b0;
            if (k == 1)     check("wrap_seq1_hdr", st_if.o_data, 32'h0002_0000);
            if (k == 32767) check("wrap_seqmax_hdr", st_if.o_data, 32'hFFFE_0000);
            tick();
        end
        check("wrap_cnt", o_pkt_cnt, 16'h8000);
        sb_en = 1'b1;
        exp_push(3'd0, 1'b1, 1'b1, 32'h0000_0000);
        send_cmd(4'd0, 3'd0, 10'd0);
        check("wrap_hdr", {st_if.o_vld, st_if.o_sop, st_if.o_eop, st_if.o_data},
              {3'b111, 32'h0000_0000});
        wait_idle("wrap_idle");
        check("wrap_cnt_after", o_pkt_cnt, 16'h8001);
        check("wrap_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dg_pkt_gen.md
# dg_pkt_gen

Packet generator for the data-generation test path. It accepts one packet command (destination, priority, length) per handshake from the command-fetch stage. It then streams a header word plus `len` payload words into one write port of the multi-port cache, under downstream backpressure. Payload content is deterministic, so the checker can regenerate every word from the header alone.

## Interface
Parameters:
- `PORT_ID`, default 0: 4-bit source port number, embedded in the payload.
- `CNT_W`, default 16: width of the sent-packet counter.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_da`  in  4  destination port of the command
- `i_prior`  in  3  priority of the command
- `i_len`  in  10  payload length in 32-bit words (0..1023)
- `i_vld`  in  1  single-cycle command strobe
- `o_ready`  out  1  generator idle; a command is accepted this cycle
- `o_data`  out  32  stream word
- `o_vld`  out  1  stream word valid
- `o_sop`  out  1  first word of packet (header)
- `o_eop`  out  1  last word of packet
- `o_prior`  out  3  priority sideband, constant for the whole packet
- `i_rdy`  in  1  downstream accepts the word when `o_vld && i_rdy`
- `o_busy`  out  1  packet in progress
- `o_pkt_cnt`  out  CNT_W  packets completed, wraps
- `o_cmd_drop`  out  1  one-cycle pulse: `i_vld` arrived while `o_ready`=0

## Operation
- States: IDLE, HDR, PAY.
- IDLE:
  - `o_ready`=1.
  - On `i_vld`, latch da, prior, len and the current seq, then go to HDR.
- HDR:
  - Drive the header with `o_sop`=1.
  - `o_eop`=1 only if len=0.
  - On accept: go to IDLE if len=0, else go to PAY with the word index at 0.
- PAY:
  - Drive payload word k.
  - `o_eop`=1 when k=len-1.
  - On accept: increment k. After the last word, go to IDLE.
- Header format:
  - [3:0] da
  - [6:4] prior
  - [16:7] len
  - [31:17] seq (15 bits)
- Payload word k format:
  - [31:28] PORT_ID
  - [27:16] seq[11:0]
  - [15:10] 0
  - [9:0] k
- Counters:
  - seq increments by 1 on acceptance of the EOP word and wraps 32767→0.
  - `o_pkt_cnt` increments at the same event and wraps at 2^CNT_W.
- `o_ready` is a decode of state==IDLE (combinational from the state register).
- `o_busy` = !`o_ready`.
- `i_vld` while not IDLE:
  - The command is discarded.
  - `o_cmd_drop` pulses the next cycle.
  - State is unaffected.

## Timing
- Reset (asynchronous):
  - State IDLE; seq=0; `o_pkt_cnt`=0.
  - `o_data`, `o_vld`, `o_sop`, `o_eop`, `o_prior`, `o_cmd_drop` = 0.
  - `o_ready`=1 after reset release; `o_busy`=0.
- Latency:
  - A command accepted at edge T produces the header with `o_vld`=1 in cycle T+1.
  - With `i_rdy` held at 1, a packet occupies len+1 consecutive cycles.
  - `o_ready` returns the cycle after EOP is accepted. The minimum command-to-command spacing is len+2 cycles.
- Backpressure:
  - While `o_vld`=1 and `i_rdy`=0, hold `o_data`, `o_sop`, `o_eop` and `o_prior` stable.
  - `o_vld` never drops mid-packet.
- `i_rdy` is ignored when `o_vld`=0.
- All outputs are registered except `o_ready` and `o_busy`.
- A reset asserted mid-packet aborts the packet with no EOP. After release the generator is IDLE with seq=0.

## Structure
- Shared package `dg_pkg` holds:
  - Header field positions: DA_LSB=0, PRIOR_LSB=4, LEN_LSB=7, SEQ_LSB=17.
  - Field widths: 4, 3, 10, 15.
  - Payload field positions.
  - State encoding for IDLE, HDR, PAY.
- No sub-module: the FSM, word-index counter, seq counter and output registers form one flat module.

## Test plan
- PORT_ID=5; command da=3, prior=2, len=3; `i_rdy`=1 → header 0x0000_01A3 with sop. Payloads 0x5000_0000, 0x5000_0001, 0x5000_0002, the last with eop. `o_pkt_cnt`=1.
- Command len=0 → a single word with sop=eop=1 in the cycle after acceptance. seq increments and `o_ready` reasserts the next cycle.
- len=4 with `i_rdy` toggling 1,0,0,1,… → exactly 5 words accepted. Outputs are stable through every stall and payload indices are 0..3 in order.
- `i_vld` pulsed during PAY → one `o_cmd_drop` pulse. The current packet is unaltered and no extra packet is produced.
- 32768 packets with len=0 → the 32769th header has seq field 0. `o_pkt_cnt`=32768.
- `rst_n` asserted in the middle of len=10 → all outputs are 0 immediately. After release `o_ready`=1, and the next packet has seq=0.
